mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles to wait for dmem_resp (0 disables the timeout).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, an asynchronous, active-low reset.
REQ-004 SHALL have valid_EXMEM, in, 1: EX/MEM holds a live instruction.
REQ-005 SHALL have mem_read_EXMEM / mem_write_EXMEM, in, 1 each: load / store.
REQ-006 SHALL have funct3_EXMEM, in, 3: load/store width and sign.
REQ-007 SHALL have alu_out_EXMEM, in, 32: effective address.
REQ-008 SHALL have rs2_data_EXMEM, in, 32: store data.
REQ-009 SHALL have wb_data_EXMEM, in, 32: writeback value for non-load instructions.
REQ-010 SHALL have rd_EXMEM, in, 5, and load_regfile_EXMEM, in, 1.
REQ-011 SHALL have dmem_address, out, 32 (word aligned); dmem_read / dmem_write, out, 1 each; dmem_wmask, out, 4; dmem_wdata, out, 32.
REQ-012 SHALL have dmem_rdata, in, 32, and dmem_resp, in, 1.
REQ-013 SHALL have stall_mem, out, 1: freezes IF/ID/EX and EX/MEM.
REQ-014 SHALL have load_regfile_MEMWB, out, 1; rd_MEMWB, out, 5; regfilemux_out_MEMWB, out, 32; commit_MEMWB, out, 1; trap_MEMWB, out, 1.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 IDLE, valid, no mem op: SHALL register wb_data/rd/load_regfile into MEMWB next edge, commit_MEMWB=1, stall_mem=0 (latency 1).
REQ-017 IDLE, valid, aligned mem op: SHALL latch address, data, wmask and funct3, go to BUSY, assert stall_mem combinationally in the same cycle, and write MEMWB as a bubble (commit=0, load_regfile=0).
REQ-018 In BUSY, SHALL hold dmem_read/dmem_write and all dmem_* outputs constant from the latched values until the dmem_resp edge.
REQ-019 In BUSY, SHALL keep stall_mem=1 except in the dmem_resp cycle, where stall_mem=0.
REQ-020 BUSY with dmem_resp=1: SHALL write MEMWB on that edge, deassert dmem_read/dmem_write, and return to IDLE; minimum memory-op latency is 2 cycles.
REQ-021 Load data SHALL be selected by addr[1:0]: LB/LBU byte, LH/LHU half at addr[1], LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-022 Stores: SB wmask=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH wmask=0011<<(2*addr[1]), wdata={2{rs2[15:0]}}; SW wmask=1111, wdata=rs2.
REQ-023 Stores SHALL produce commit_MEMWB=1 and load_regfile_MEMWB=0 in the writeback.
REQ-024 dmem_wmask SHALL be 0000 whenever dmem_write=0.
REQ-025 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no dmem request, stay IDLE, and write MEMWB with trap=1, commit=1, load_regfile=0.
REQ-026 A BUSY cycle counter SHALL reset on BUSY entry.
REQ-027 When the BUSY counter reaches TIMEOUT_CYCLES (if nonzero), the block SHALL deassert the request, write MEMWB with trap=1, commit=1, load_regfile=0, and return to IDLE.
REQ-028 SHALL force load_regfile_MEMWB=0 whenever rd=0.
REQ-029 SHALL ignore EX/MEM inputs while BUSY; EX/MEM is frozen by stall_mem.
REQ-030 dmem_resp in IDLE SHALL be ignored.

Reset
REQ-031 On rst=0, SHALL asynchronously return the FSM to IDLE and clear the counter.
REQ-032 On rst=0, all outputs SHALL be 0 (MEMWB fields, dmem_*, stall_mem, trap, commit).
REQ-033 Reset during BUSY SHALL drop the request immediately with no writeback.
REQ-034 Release of rst SHALL take effect on the next clk edge.

Structure
REQ-035 The mem_state_t enum SHALL live in mp4_types; load/store funct3 encodings SHALL come from rv32i_types.
REQ-036 Load extraction SHALL be a combinational sub-module load_formatter (rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-037 Bench SHALL cover: ALU op, wb_data=0x1234, rd=5 -> next cycle MEMWB load=1, rd=5, data 0x1234, stall_mem=0.
REQ-038 Bench SHALL cover: LB at 0x103, dmem_rdata=0x80FFFFFF, resp after 3 cycles -> dmem_address 0x100, stall for 3 cycles, result 0xFFFFFF80; LBU gives 0x00000080.
REQ-039 Bench SHALL cover: SH at 0x202, rs2=0xABCD1234 -> wmask 1100, wdata 0x12341234, commit=1, load_regfile=0.
REQ-040 Bench SHALL cover: LW at 0x301 -> no dmem_read, trap_MEMWB=1, stall_mem=0.
REQ-041 Bench SHALL cover: TIMEOUT_CYCLES=4 with dmem_resp never arriving -> request drops after 4 BUSY cycles, trap=1.
REQ-042 Bench SHALL cover: rst=0 mid-BUSY -> dmem_read=0 asynchronously and no writeback.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: RV32I load/store funct3 encodings and MEM stage FSM types
package rv32i_types;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;
  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
endpackage

package mp4_types;
  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_stage_load_formatter.sv
// load_formatter: picks and extends the addressed byte/half/word of a load response
module load_formatter
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    result = funct3 == LB  ? {{24{b[7]}}, b} :
             funct3 == LBU ? {24'b0, b} :
             funct3 == LH  ? {{16{h[15]}}, h} :
             funct3 == LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a blocking data-memory handshake, alignment traps and timeout
module mem_stage
  import mp4_types::*;
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_EXMEM,
  input  logic        mem_read_EXMEM,
  input  logic        mem_write_EXMEM,
  input  logic [2:0]  funct3_EXMEM,
  input  logic [31:0] alu_out_EXMEM,
  input  logic [31:0] rs2_data_EXMEM,
  input  logic [31:0] wb_data_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  input  logic        load_regfile_EXMEM,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_mem,
  output logic        load_regfile_MEMWB,
  output logic [4:0]  rd_MEMWB,
  output logic [31:0] regfilemux_out_MEMWB,
  output logic        commit_MEMWB,
  output logic        trap_MEMWB
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  mem_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] wdata_q, load_data, wdata_n;
  logic [3:0]  wmask_q, wmask_n;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        lr_q, rd_op_q, wr_q;
  logic        busy, mem_op, mis, issue, timeout, done;
  always_comb begin
    busy = state == MEM_BUSY;
    mem_op = mem_read_EXMEM | mem_write_EXMEM;
    mis = misaligned(funct3_EXMEM, alu_out_EXMEM[1:0]);
    issue = !busy && valid_EXMEM && mem_op && !mis;
    timeout = busy && !dmem_resp && (TIMEOUT_CYCLES != 0) && cnt == CW'(TIMEOUT_CYCLES - 1);
    done = busy && (dmem_resp || timeout);
    stall_mem = rst && (issue || (busy && !done));
    dmem_read = busy && rd_op_q;
    dmem_write = busy && wr_q;
    dmem_wmask = dmem_write ? wmask_q : 4'b0000;
    dmem_wdata = wdata_q;
    wmask_n = funct3_EXMEM == SB ? 4'b0001 << alu_out_EXMEM[1:0] :
              funct3_EXMEM == SH ? 4'b0011 << {alu_out_EXMEM[1], 1'b0} : 4'b1111;
    wdata_n = funct3_EXMEM == SB ? {4{rs2_data_EXMEM[7:0]}} :
              funct3_EXMEM == SH ? {2{rs2_data_EXMEM[15:0]}} : rs2_data_EXMEM;
  end
  load_formatter u_fmt (
    .rdata (dmem_rdata),
    .offset(off_q),
    .funct3(f3_q),
    .result(load_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MEM_IDLE;
      cnt <= '0;
      dmem_address <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      rd_q <= '0;
      lr_q <= 1'b0;
      rd_op_q <= 1'b0;
      wr_q <= 1'b0;
      load_regfile_MEMWB <= 1'b0;
      rd_MEMWB <= '0;
      regfilemux_out_MEMWB <= '0;
      commit_MEMWB <= 1'b0;
      trap_MEMWB <= 1'b0;
    end else begin
      load_regfile_MEMWB <= 1'b0;
      commit_MEMWB <= 1'b0;
      trap_MEMWB <= 1'b0;
      if (busy) begin
        cnt <= cnt + 1'b1;
        if (done) begin
          state <= MEM_IDLE;
          commit_MEMWB <= 1'b1;
          trap_MEMWB <= timeout;
          load_regfile_MEMWB <= !timeout && rd_op_q && lr_q && rd_q != 5'd0;
          rd_MEMWB <= rd_q;
          regfilemux_out_MEMWB <= (rd_op_q && !timeout) ? load_data : 32'h0;
        end
      end else if (valid_EXMEM) begin
        rd_MEMWB <= rd_EXMEM;
        regfilemux_out_MEMWB <= mem_op ? 32'h0 : wb_data_EXMEM;
        if (!mem_op) begin
          commit_MEMWB <= 1'b1;
          load_regfile_MEMWB <= load_regfile_EXMEM && rd_EXMEM != 5'd0;
        end else if (mis) begin
          commit_MEMWB <= 1'b1;
          trap_MEMWB <= 1'b1;
        end else begin
          // latch the whole request so EX/MEM contents no longer matter while BUSY
          state <= MEM_BUSY;
          cnt <= '0;
          dmem_address <= {alu_out_EXMEM[31:2], 2'b00};
          wdata_q <= wdata_n;
          wmask_q <= wmask_n;
          f3_q <= funct3_EXMEM;
          off_q <= alu_out_EXMEM[1:0];
          rd_q <= rd_EXMEM;
          lr_q <= load_regfile_EXMEM;
          rd_op_q <= mem_read_EXMEM;
          wr_q <= mem_write_EXMEM && !mem_read_EXMEM;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus timeout, idle-resp and async-reset sequences
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, lr = 1'b0, resp = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, rs2 = '0, wb = '0, rdata = '0;
  logic [4:0]  rd = '0;
  logic [31:0] dmem_address, regfilemux_out_MEMWB, dmem_wdata;
  logic        dmem_read, dmem_write, stall_mem, load_regfile_MEMWB, commit_MEMWB, trap_MEMWB;
  logic [3:0]  dmem_wmask;
  logic [4:0]  rd_MEMWB;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    bit        valid, mrd, mwr;
    bit [2:0]  f3;
    bit [31:0] addr, rs2, wb;
    bit [4:0]  rd;
    bit        lr;
    bit [31:0] rdata;
    int        lat;
    bit [3:0]  e_wmask;
    bit [31:0] e_wdata;
    bit        e_commit, e_load, e_trap;
    bit [31:0] e_data;
    bit        chk_data;
  } vec_t;
  vec_t vecs[16];

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_EXMEM(valid), .mem_read_EXMEM(mem_read),
    .mem_write_EXMEM(mem_write), .funct3_EXMEM(funct3), .alu_out_EXMEM(addr),
    .rs2_data_EXMEM(rs2), .wb_data_EXMEM(wb), .rd_EXMEM(rd), .load_regfile_EXMEM(lr),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(rdata), .dmem_resp(resp),
    .stall_mem(stall_mem), .load_regfile_MEMWB(load_regfile_MEMWB), .rd_MEMWB(rd_MEMWB),
    .regfilemux_out_MEMWB(regfilemux_out_MEMWB), .commit_MEMWB(commit_MEMWB), .trap_MEMWB(trap_MEMWB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    valid = v.valid; mem_read = v.mrd; mem_write = v.mwr; funct3 = v.f3; addr = v.addr;
    rs2 = v.rs2; wb = v.wb; rd = v.rd; lr = v.lr; rdata = v.rdata; resp = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d stall_issue", idx), stall_mem, v.lat != 0);
    for (int i = 1; i <= v.lat; i++) begin
      @(posedge clk); #1;
      valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; wb = 32'h5555AAAA; rd = 5'd9; lr = 1'b1;
      addr = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      resp = (i == v.lat);
      @(negedge clk);
      chk($sformatf("v%0d dmem_read", idx), dmem_read, v.mrd);
      chk($sformatf("v%0d dmem_write", idx), dmem_write, v.mwr);
      chk($sformatf("v%0d dmem_address", idx), dmem_address, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d dmem_wmask", idx), dmem_wmask, v.e_wmask);
      if (v.mwr) chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.e_wdata);
      chk($sformatf("v%0d stall_busy", idx), stall_mem, i != v.lat);
    end
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; resp = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d commit", idx), commit_MEMWB, v.e_commit);
    chk($sformatf("v%0d load_regfile", idx), load_regfile_MEMWB, v.e_load);
    chk($sformatf("v%0d trap", idx), trap_MEMWB, v.e_trap);
    if (v.e_load) chk($sformatf("v%0d rd", idx), rd_MEMWB, v.rd);
    if (v.chk_data) chk($sformatf("v%0d data", idx), regfilemux_out_MEMWB, v.e_data);
    chk($sformatf("v%0d read_after", idx), dmem_read, 0);
    chk($sformatf("v%0d write_after", idx), dmem_write, 0);
    chk($sformatf("v%0d wmask_after", idx), dmem_wmask, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          valid mrd mwr f3 addr  rs2  wb  rd lr rdata  lat wmask wdata commit load trap data chk
    vecs[0]  = '{1, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1, 32'h0, 0, 4'h0, 32'h0, 1, 1, 0, 32'h1234, 1};
    vecs[1]  = '{1, 0, 0, 3'd0, 32'h0, 32'h0, 32'hBEEF, 5'd0, 1, 32'h0, 0, 4'h0, 32'h0, 1, 0, 0, 32'hBEEF, 1};
    vecs[2]  = '{1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h0, 5'd7, 1, 32'h80FFFFFF, 3, 4'h0, 32'h0, 1, 1, 0, 32'hFFFFFF80, 1};
    vecs[3]  = '{1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h0, 5'd7, 1, 32'h80FFFFFF, 3, 4'h0, 32'h0, 1, 1, 0, 32'h00000080, 1};
    vecs[4]  = '{1, 1, 0, 3'd1, 32'h102, 32'h0, 32'h0, 5'd4, 1, 32'h80017FFF, 1, 4'h0, 32'h0, 1, 1, 0, 32'hFFFF8001, 1};
    vecs[5]  = '{1, 1, 0, 3'd5, 32'h100, 32'h0, 32'h0, 5'd4, 1, 32'h1234F00D, 2, 4'h0, 32'h0, 1, 1, 0, 32'h0000F00D, 1};
    vecs[6]  = '{1, 1, 0, 3'd2, 32'h300, 32'h0, 32'h0, 5'd31, 1, 32'hDEADBEEF, 2, 4'h0, 32'h0, 1, 1, 0, 32'hDEADBEEF, 1};
    vecs[7]  = '{1, 1, 0, 3'd0, 32'h101, 32'h0, 32'h0, 5'd2, 1, 32'h11223344, 1, 4'h0, 32'h0, 1, 1, 0, 32'h00000033, 1};
    vecs[8]  = '{1, 0, 1, 3'd1, 32'h202, 32'hABCD1234, 32'h0, 5'd3, 1, 32'h0, 1, 4'hC, 32'h12341234, 1, 0, 0, 32'h0, 0};
    vecs[9]  = '{1, 0, 1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 5'd3, 0, 32'h0, 2, 4'h2, 32'hA5A5A5A5, 1, 0, 0, 32'h0, 0};
    vecs[10] = '{1, 0, 1, 3'd2, 32'h204, 32'hCAFEF00D, 32'h0, 5'd3, 0, 32'h0, 1, 4'hF, 32'hCAFEF00D, 1, 0, 0, 32'h0, 0};
    vecs[11] = '{1, 1, 0, 3'd2, 32'h301, 32'h0, 32'h0, 5'd6, 1, 32'h0, 0, 4'h0, 32'h0, 1, 0, 1, 32'h0, 0};
    vecs[12] = '{1, 0, 1, 3'd1, 32'h203, 32'h0, 32'h0, 5'd6, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, 1, 32'h0, 0};
    vecs[13] = '{1, 1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 5'd6, 1, 32'h0, 0, 4'h0, 32'h0, 1, 0, 1, 32'h0, 0};
    vecs[14] = '{0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h7777, 5'd5, 1, 32'h0, 0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 0};
    vecs[15] = '{1, 1, 0, 3'd2, 32'h108, 32'h0, 32'h0, 5'd0, 1, 32'h00000001, 1, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst dmem_read", dmem_read, 0);
    chk("rst dmem_write", dmem_write, 0);
    chk("rst dmem_address", dmem_address, 0);
    chk("rst dmem_wmask", dmem_wmask, 0);
    chk("rst stall", stall_mem, 0);
    chk("rst commit", commit_MEMWB, 0);
    chk("rst trap", trap_MEMWB, 0);
    chk("rst load_regfile", load_regfile_MEMWB, 0);
    chk("rst data", regfilemux_out_MEMWB, 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
    // dmem_resp while idle must not create a writeback
    @(posedge clk); #1;
    resp = 1'b1; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("idle_resp stall", stall_mem, 0);
    chk("idle_resp read", dmem_read, 0);
    @(posedge clk); #1;
    resp = 1'b0;
    @(negedge clk);
    chk("idle_resp commit", commit_MEMWB, 0);
    chk("idle_resp load", load_regfile_MEMWB, 0);
    chk("idle_resp trap", trap_MEMWB, 0);
    // timeout: no response ever, request must drop after 4 BUSY cycles
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h400; rd = 5'd8; lr = 1'b1;
    @(negedge clk);
    chk("to stall_issue", stall_mem, 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      valid = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      chk($sformatf("to read c%0d", i), dmem_read, 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to read_dropped", dmem_read, 0);
    chk("to trap", trap_MEMWB, 1);
    chk("to commit", commit_MEMWB, 1);
    chk("to load", load_regfile_MEMWB, 0);
    chk("to stall_after", stall_mem, 0);
    // asynchronous reset while BUSY
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h500; rd = 5'd9; lr = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("ar read_busy", dmem_read, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar read_async", dmem_read, 0);
    chk("ar stall_async", stall_mem, 0);
    chk("ar address_async", dmem_address, 0);
    resp = 1'b1; rdata = 32'h12345678;
    @(posedge clk); #1;
    chk("ar commit", commit_MEMWB, 0);
    chk("ar load", load_regfile_MEMWB, 0);
    chk("ar rd", rd_MEMWB, 0);
    chk("ar data", regfilemux_out_MEMWB, 0);
    resp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_vec(100, vecs[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
